am_demodulator: RTL and testbench
=================================

# am_demodulator

Receive-side counterpart of the beeper's AM modulator. It takes the 8-bit offset-binary AM stream produced by the modulator (or an ADC looking at the same band) and recovers the baseband audio. The datapath is full-wave rectify, then boxcar-decimate, then leaky-integrator carrier/DC removal. It sits between the sample source and the audio sink and emits one signed 16-bit audio sample per decimation block with a one-cycle valid strobe.

## Interface

- `DECIM_LOG2`, default 6: log2 of samples per output block. Legal range 1..9.
- `DC_SHIFT`, default 10: leak shift of the carrier-level integrator. Legal range 1..15.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in` is valid this cycle. May be high every cycle or sparse.
- `in`  in  8: unsigned offset-binary sample; 128 means zero.
- `out_valid`  out  1: one-cycle strobe marking a new `out` / `carrier_level`.
- `out`  out  16: signed audio, i.e. envelope minus carrier level, saturated.
- `carrier_level`  out  16: unsigned tracked carrier (envelope mean).

## Operation

- **Stage 1** (on `in_valid`): `s = in - 128`, signed 9 bits; the valid bit is registered alongside.
- **Stage 2**: `r = |s|`, unsigned 8 bits, range 0..128 (`in=0` gives 128, `in=255` gives 127).
- **Stage 3**: boxcar accumulator `acc` of width 8+DECIM_LOG2+1 and sample counter `cnt` of width DECIM_LOG2. Both advance only on stage-2-valid.
  - When `cnt == 2^DECIM_LOG2-1`: `sum = acc + r`, `acc` clears to 0, `cnt` wraps to 0, and `env_valid` is set for one cycle.
- **Envelope scaling**: `env16 = sum << (9-DECIM_LOG2)`, saturated to 65535. The only saturating case is all samples at 0, which gives 65536.
- **Stage 4** (on `env_valid`):
  - `dc_old = dc_acc >> DC_SHIFT`.
  - `out = sat16(env16 - dc_old)`, computed in 17-bit signed and clamped to [-32768, 32767].
  - `carrier_level = (dc_acc + env16 - dc_old) >> DC_SHIFT`.
  - `dc_acc <= dc_acc + env16 - dc_old`. `dc_acc` is unsigned, 16+DC_SHIFT bits, and cannot overflow.
  - `out_valid = 1` for one cycle.
- `out` and `carrier_level` hold their value between strobes.
- There is no backpressure. The pipeline never stalls; gaps in `in_valid` simply propagate as bubbles.
- **Reset**: all pipeline valid bits, `acc`, `cnt`, `dc_acc`, `out`, `carrier_level` and `out_valid` go to 0.
  - Samples in flight are discarded, and a partially filled block is lost.
  - The first block after reset begins with the first `in_valid` sample seen while `reset` is low.

## Timing

- The pipeline is four registered stages. A sample captured at edge E reaches stage 2 at E+1, the accumulator at E+2, and the output registers at E+3.
- The last sample of a block captured at edge E makes `out_valid` high in the cycle following edge E+3. Latency is 4 clocks.
- With continuous `in_valid`, `out_valid` pulses exactly every 2^DECIM_LOG2 cycles. With sparse input, a pulse occurs once per 2^DECIM_LOG2 accepted samples.
- `reset` high at an edge overrides all other updates at that edge. `out_valid` is 0 in the cycle after any reset edge.
- `in_valid` during `reset` is ignored.
- A block boundary coinciding with a new `in_valid` needs no special handling: the boundary sample closes the block, and the next sample starts the fresh block at stage 3 one cycle later.
- Back-to-back blocks are allowed with DECIM_LOG2=1, giving `out_valid` every 2 cycles with no lost samples.

## Test plan

- **Reset values**: hold `reset` for 3 cycles -> `out=0`, `carrier_level=0`, `out_valid=0`. Verify the same after any mid-run reset.
- **Silence**: DECIM_LOG2=6, `in=128` continuous -> `out_valid` every 64 cycles, first pulse in the cycle after edge 63+3 counted from the first accepted sample. `out=0` and `carrier_level=0` always.
- **Constant carrier**: `in=192` continuous, defaults -> first `out=32767` (saturated from 32768), `carrier_level=32`. Second `out=32736`, `carrier_level=63`. Over ~10k blocks `carrier_level` converges to 32768 ±1 and `out` decays to 0 ±1.
- **Full-scale alternation**: `in` toggling 0/255 -> `env16=65280`. First block gives `out=32767` (saturated), `carrier_level=63`. There is no `env16` saturation.
- **Sparse input**: `in=192` with `in_valid` every 3rd cycle -> `out_valid` every 192 cycles. The value sequence is identical to the constant-carrier test.
- **Mid-block reset**: feed 30 samples of `in=0`, pulse `reset` for 1 cycle, then feed `in=192` continuously -> no `out_valid` until 64 post-reset samples. The first `out=32767` with `carrier_level=32`, showing that no pre-reset contribution leaked through.

Source files
------------

// File: rtl/am_demodulator.sv
// AM envelope demodulator: full-wave rectify, boxcar-decimate by 2^DECIM_LOG2,
// then subtract a leaky-integrator estimate of the carrier level.
module am_demodulator #(
    parameter int DECIM_LOG2 = 6,
    parameter int DC_SHIFT   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out_valid,
    output logic signed [15:0] out,
    output logic [15:0]        carrier_level
);

    localparam int AW = 8 + DECIM_LOG2 + 1;
    localparam int DW = 16 + DC_SHIFT;

    // Stage 1: offset-binary to signed
    logic signed [8:0] s1_q;
    logic              v1_q;

    // Stage 2: magnitude
    logic [8:0]        abs_s1;
    logic [7:0]        r2_q;
    logic              v2_q;

    // Stage 3: boxcar accumulator
    logic [AW-1:0]         acc_q, acc_d;
    logic [AW-1:0]         sum_q, sum_d;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic                  env_valid_q, env_valid_d;

    // Stage 4: carrier tracking and output
    logic [17:0]              env_wide;
    logic [15:0]              env16;
    logic [15:0]              dc_old;
    logic signed [16:0]       diff;
    logic signed [15:0]       out_d, out_q;
    logic [DW-1:0]            dc_acc_q, dc_next;
    logic [15:0]              carrier_d, carrier_q;
    logic                     out_valid_q;

    assign abs_s1 = s1_q[8] ? (~s1_q + 9'd1) : s1_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, giving a true pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            s1_q <= '0;
            v2_q <= 1'b0;
            r2_q <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_q <= $signed({1'b0, in}) - 9'sd128;
            end
            v2_q <= v1_q;
            r2_q <= abs_s1[7:0];
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        env_valid_d = 1'b0;
        if (v2_q) begin
            if (cnt_q == '1) begin
                sum_d       = acc_q + AW'(r2_q);
                acc_d       = '0;
                cnt_d       = '0;
                env_valid_d = 1'b1;
            end else begin
                acc_d = acc_q + AW'(r2_q);
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            env_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            env_valid_q <= env_valid_d;
        end
    end

    // Block sum scaled to 16 bits; only an all-zero-input block reaches 65536.
    assign env_wide = 18'(sum_q) << (9 - DECIM_LOG2);
    assign env16    = (env_wide[17:16] != 2'b00) ? 16'hFFFF : env_wide[15:0];

    always_comb begin
        dc_old    = 16'(dc_acc_q >> DC_SHIFT);
        diff      = $signed({1'b0, env16}) - $signed({1'b0, dc_old});
        out_d     = diff[15:0];
        if (diff > 17'sd32767) begin
            out_d = 16'sh7FFF;
        end else if (diff < -17'sd32768) begin
            out_d = -16'sh8000;
        end
        // dc_acc never drops below dc_old << DC_SHIFT, so the subtraction is safe.
        dc_next   = dc_acc_q + DW'(env16) - DW'(dc_old);
        carrier_d = 16'(dc_next >> DC_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dc_acc_q    <= '0;
            out_q       <= '0;
            carrier_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= env_valid_q;
            if (env_valid_q) begin
                dc_acc_q  <= dc_next;
                out_q     <= out_d;
                carrier_q <= carrier_d;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out           = out_q;
    assign carrier_level = carrier_q;

endmodule

// File: tb/tb_am_demodulator.sv
// Randomised and directed bench for am_demodulator, scored against a
// block-level arithmetic model of rectify/average/carrier-tracking.
module tb_am_demodulator;

    localparam int D   = 6;
    localparam int DCS = 10;
    localparam int BLK = 1 << D;

    typedef struct { int o; int c; int due; } exp_t;
    typedef struct { int o; int c; int cyc; } obs_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic [7:0]         in_s = 8'd0;
    logic               out_valid;
    logic signed [15:0] out_s;
    logic [15:0]        carrier_level;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   blk_sum, blk_n;
    longint dc_m;
    int   last_o, last_c;
    bit   rst_prev = 1'b0;

    am_demodulator #(.DECIM_LOG2(D), .DC_SHIFT(DCS)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in            (in_s),
        .out_valid     (out_valid),
        .out           (out_s),
        .carrier_level (carrier_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int expv);
        n_total++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    endtask

    function automatic void model_reset();
        blk_sum = 0;
        blk_n   = 0;
        dc_m    = 0;
        last_o  = 0;
        last_c  = 0;
        exp_q.delete();
    endfunction

    // Average |x-128| over a block, scale to 16 bits, then a 1/2^DCS leaky mean.
    function automatic void model_push(input int x, input int due);
        longint env, old, d;
        exp_t e;
        blk_sum += (x >= 128) ? (x - 128) : (128 - x);
        blk_n++;
        if (blk_n == BLK) begin
            env = longint'(blk_sum) * (1 << (9 - D));
            if (env > 65535) env = 65535;
            old = dc_m / (1 << DCS);
            d   = env - old;
            if (d > 32767) d = 32767;
            if (d < -32768) d = -32768;
            dc_m = dc_m + env - old;
            e.o = int'(d);
            e.c = int'(dc_m / (1 << DCS));
            e.due = due;
            exp_q.push_back(e);
            blk_sum = 0;
            blk_n   = 0;
        end
    endfunction

    // One cycle: observe outputs on the falling edge, then drive the next inputs.
    task automatic step(input bit v, input int x, input bit rst);
        exp_t e;
        obs_t ob;
        @(negedge clk);
        if (rst_prev) begin
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out", int'(out_s), 0);
            check("rst_carrier", int'(carrier_level), 0);
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out", int'(out_s), e.o);
                check("carrier", int'(carrier_level), e.c);
                check("latency", cyc, e.due);
                last_o = e.o;
                last_c = e.c;
            end
            ob.o = int'(out_s);
            ob.c = int'(carrier_level);
            ob.cyc = cyc;
            obs_q.push_back(ob);
        end else begin
            if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                check("missing_valid", 0, 1);
                e = exp_q.pop_front();
                last_o = e.o;
                last_c = e.c;
            end
            check("hold_out", int'(out_s), last_o);
            check("hold_carrier", int'(carrier_level), last_c);
        end
        reset    = rst;
        in_valid = v;
        in_s     = 8'(x);
        rst_prev = rst;
        if (rst) model_reset();
        else if (v) model_push(x, cyc + 4);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, $urandom_range(0, 255), 1'b1);
        obs_q.delete();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);

        // Reset values and silence
        do_reset(3);
        for (int i = 0; i < 3 * BLK + 6; i++) step(1'b1, 128, 1'b0);
        check("silence_pulses", obs_q.size(), 3);
        if (obs_q.size() >= 2) check("silence_period", obs_q[1].cyc - obs_q[0].cyc, BLK);

        // Constant carrier
        do_reset(3);
        for (int i = 0; i < 20 * BLK + 6; i++) step(1'b1, 192, 1'b0);
        check("const_pulses", obs_q.size(), 20);
        if (obs_q.size() >= 2) begin
            check("const_out0", obs_q[0].o, 32767);
            check("const_car0", obs_q[0].c, 32);
            check("const_out1", obs_q[1].o, 32736);
            check("const_car1", obs_q[1].c, 63);
        end

        // Full-scale alternation
        do_reset(3);
        for (int i = 0; i < 3 * BLK + 6; i++) step(1'b1, (i % 2) ? 255 : 0, 1'b0);
        if (obs_q.size() >= 1) begin
            check("alt_out0", obs_q[0].o, 32767);
            check("alt_car0", obs_q[0].c, 63);
        end

        // Sparse input, one sample every third cycle
        do_reset(3);
        for (int i = 0; i < 3 * 3 * BLK + 6; i++) step(i % 3 == 0, 192, 1'b0);
        check("sparse_pulses", obs_q.size(), 3);
        if (obs_q.size() >= 2) begin
            check("sparse_period", obs_q[1].cyc - obs_q[0].cyc, 3 * BLK);
            check("sparse_out0", obs_q[0].o, 32767);
            check("sparse_car0", obs_q[0].c, 32);
            check("sparse_out1", obs_q[1].o, 32736);
            check("sparse_car1", obs_q[1].c, 63);
        end

        // Mid-block reset discards the partial block
        do_reset(3);
        for (int i = 0; i < 30; i++) step(1'b1, 0, 1'b0);
        do_reset(1);
        for (int i = 0; i < 2 * BLK + 6; i++) step(1'b1, 192, 1'b0);
        check("midrst_pulses", obs_q.size(), 2);
        if (obs_q.size() >= 1) begin
            check("midrst_out0", obs_q[0].o, 32767);
            check("midrst_car0", obs_q[0].c, 32);
        end

        // Random samples, random gaps, occasional resets
        do_reset(2);
        for (int i = 0; i < 6000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 599) == 0);
        end

        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b0);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
